// File: rtl/clk_en_gen_pkg.sv
// Shared types and divider helpers for the clock-enable generator.
// Divisors 0/1 collapse to 1; a phase outside its period collapses to 0.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_PLL = 2'd0,
        SETTLE   = 2'd1,
        RUN      = 2'd2
    } state_t;

    function automatic int unsigned eff_div(input int unsigned d);
        return (d <= 32'd1) ? 32'd1 : d;
    endfunction

    function automatic int unsigned eff_phase(input int unsigned p, input int unsigned d);
        return (p >= eff_div(d)) ? 32'd0 : p;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: period counter plus a single-entry config shadow.
// o_hit is a decode of registered state; shadow updates land only at a wrap or a load.
module clk_en_chan
    import clk_en_gen_pkg::*;
#(
    parameter int               DIV_W     = 8,
    parameter logic [DIV_W-1:0] DEF_DIV   = DIV_W'(2),
    parameter logic [DIV_W-1:0] DEF_PHASE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_load,
    input  logic             i_acc,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [DIV_W-1:0] i_cfg_phase,
    output logic             o_hit,
    output logic             o_pend
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_sh_div;
    logic [DIV_W-1:0] r_sh_phase;
    logic             r_pend;

    logic [DIV_W-1:0] w_ediv;
    logic [DIV_W-1:0] w_ld_div;
    logic [DIV_W-1:0] w_ld_phase;
    logic [DIV_W-1:0] w_ld_cnt;
    logic             w_wrap;

    assign w_ediv     = DIV_W'(eff_div(32'(r_div)));
    assign w_wrap     = (r_cnt == (w_ediv - ONE));
    // A load consumes any pending shadow before picking the start phase.
    assign w_ld_div   = r_pend ? r_sh_div   : r_div;
    assign w_ld_phase = r_pend ? r_sh_phase : r_phase;
    assign w_ld_cnt   = DIV_W'(eff_phase(32'(w_ld_phase), 32'(w_ld_div)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div      <= DEF_DIV;
            r_phase    <= DEF_PHASE;
            r_sh_div   <= DEF_DIV;
            r_sh_phase <= DEF_PHASE;
            r_pend     <= 1'b0;
        end else begin
            if (i_load) begin
                r_cnt   <= w_ld_cnt;
                r_div   <= w_ld_div;
                r_phase <= w_ld_phase;
                r_pend  <= 1'b0;
            end else if (i_run) begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    if (r_pend) begin
                        r_div   <= r_sh_div;
                        r_phase <= r_sh_phase;
                        r_pend  <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
            end
            // An accept coinciding with a wrap or load lands after it, never in it.
            if (i_acc) begin
                r_sh_div   <= i_cfg_div;
                r_sh_phase <= i_cfg_phase;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_hit  = w_wrap;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel divide-by-N enable generator gated on a synchronised PLL lock.
// locked rises 2+1+LOCK_CYCLES cycles after pll_locked; cfg_ready drops while any shadow is pending.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int                     NCH         = 2,
    parameter int                     DIV_W       = 8,
    parameter logic [NCH*DIV_W-1:0]   DEF_DIV     = {8'd4, 8'd2},
    parameter logic [NCH*DIV_W-1:0]   DEF_PHASE   = '0,
    parameter int                     LOCK_CYCLES = 16,
    parameter int                     SYNC_STAGES = 2,
    localparam int                    CW          = $clog2(NCH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CW-1:0]    cfg_chan,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             cfg_err,
    input  logic             realign,
    output logic [NCH-1:0]   en,
    output logic             locked
);

    localparam int SCW = $clog2(LOCK_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [SCW-1:0]         r_scnt;
    logic                   r_locked;
    logic                   r_rl;
    logic                   r_err;

    logic                   w_lk_s;
    logic                   w_acc;
    logic                   w_bad;
    logic                   w_rl;
    logic                   w_load;
    logic                   w_run;
    logic [NCH-1:0]         w_hit;
    logic [NCH-1:0]         w_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lk_s    = r_sync[SYNC_STAGES-1];
    assign cfg_ready = ~|w_pend;
    assign w_acc     = cfg_valid & cfg_ready;
    assign w_bad     = (cfg_chan >= CW'(NCH));
    assign w_rl      = (r_state == RUN) & w_lk_s & realign;
    assign w_load    = ((r_state == WAIT_PLL) & w_lk_s) | w_rl;
    assign w_run     = (r_state != WAIT_PLL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT_PLL;
            r_scnt   <= '0;
            r_locked <= 1'b0;
            r_rl     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rl  <= w_rl;
            r_err <= w_acc & w_bad;
            case (r_state)
                WAIT_PLL: begin
                    if (w_lk_s) begin
                        r_state <= SETTLE;
                        r_scnt  <= '0;
                    end
                end
                SETTLE: begin
                    if (!w_lk_s) begin
                        r_state <= WAIT_PLL;
                        r_scnt  <= '0;
                    end else if (r_scnt == SCW'(LOCK_CYCLES - 1)) begin
                        r_state  <= RUN;
                        r_locked <= 1'b1;
                        r_scnt   <= '0;
                    end else begin
                        r_scnt <= r_scnt + SCW'(1);
                    end
                end
                RUN: begin
                    if (!w_lk_s) begin
                        r_state  <= WAIT_PLL;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= WAIT_PLL;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_en_chan #(
            .DIV_W     (DIV_W),
            .DEF_DIV   (DEF_DIV[g*DIV_W +: DIV_W]),
            .DEF_PHASE (DEF_PHASE[g*DIV_W +: DIV_W])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_run       (w_run),
            .i_load      (w_load),
            .i_acc       (w_acc & ~w_bad & (cfg_chan == CW'(g))),
            .i_cfg_div   (cfg_div),
            .i_cfg_phase (cfg_phase),
            .o_hit       (w_hit[g]),
            .o_pend      (w_pend[g])
        );
    end

    // The cycle right after a realign load is kept quiet even if a counter lands on its last count.
    assign en      = {NCH{(r_state == RUN) & ~r_rl}} & w_hit;
    assign locked  = r_locked;
    assign cfg_err = r_err;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed plus random bench for clk_en_gen against a lock-run-length / period-position model.
module tb_clk_en_gen;

    localparam int NCH  = 2;
    localparam int L    = 16;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       cfg_valid;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       realign;
    logic       cfg_ready;
    logic       cfg_err;
    logic [1:0] en;
    logic       locked;

    int ncmp  = 0;
    int nfail = 0;

    clk_en_gen dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .realign    (realign),
        .en         (en),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Model: lock state is the number of consecutive synced-high samples; channels track position in period.
    int m_div [NCH];
    int m_ph  [NCH];
    int m_pos [NCH];
    int m_sdiv[NCH];
    int m_sph [NCH];
    bit m_pend[NCH];
    int m_lkrun;
    bit m_supp;
    bit m_err;
    bit m_acc;
    bit q_lk[$];

    function automatic int edv(input int d);
        return (d <= 1) ? 1 : d;
    endfunction

    function automatic int eph(input int p, input int d);
        return (p >= edv(d)) ? 0 : p;
    endfunction

    function automatic bit m_ready();
        bit r = 1'b1;
        for (int i = 0; i < NCH; i++) if (m_pend[i]) r = 1'b0;
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_en();
        logic [NCH-1:0] e = '0;
        for (int i = 0; i < NCH; i++)
            e[i] = (m_lkrun > L) && !m_supp && (m_pos[i] == edv(m_div[i]) - 1);
        return e;
    endfunction

    task automatic model_reset();
        m_div[0] = 2; m_div[1] = 4;
        for (int i = 0; i < NCH; i++) begin
            m_ph[i] = 0; m_pos[i] = 0; m_pend[i] = 1'b0;
            m_sdiv[i] = m_div[i]; m_sph[i] = 0;
        end
        m_lkrun = 0; m_supp = 1'b0; m_err = 1'b0; m_acc = 1'b0;
        q_lk.delete();
        repeat (SYNC) q_lk.push_back(1'b0);
    endtask

    task automatic model_step();
        bit lk, was_wait, was_run, load;
        m_acc = cfg_valid && m_ready();
        lk = q_lk.pop_front();
        q_lk.push_back(pll_locked);
        was_wait = (m_lkrun == 0);
        was_run  = (m_lkrun > L);
        load     = lk && (was_wait || (was_run && realign));
        for (int i = 0; i < NCH; i++) begin
            if (load) begin
                if (m_pend[i]) begin
                    m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 1'b0;
                end
                m_pos[i] = eph(m_ph[i], m_div[i]);
            end else if (!was_wait) begin
                if (m_pos[i] == edv(m_div[i]) - 1) begin
                    m_pos[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 1'b0;
                    end
                end else begin
                    m_pos[i]++;
                end
            end
        end
        if (m_acc && cfg_chan < NCH) begin
            m_sdiv[cfg_chan] = cfg_div;
            m_sph[cfg_chan]  = cfg_phase;
            m_pend[cfg_chan] = 1'b1;
        end
        m_err   = m_acc && (cfg_chan >= NCH);
        m_supp  = lk && was_run && realign;
        m_lkrun = lk ? ((m_lkrun > L) ? L + 1 : m_lkrun + 1) : 0;
    endtask

    task automatic check(input string tag);
        logic [NCH-1:0] ee;
        ee = m_en();
        ncmp++;
        assert (en === ee) else begin
            nfail++; $error("FAIL %s en: got %b want %b", tag, en, ee);
        end
        ncmp++;
        assert (locked === (m_lkrun > L)) else begin
            nfail++; $error("FAIL %s locked: got %b want %b", tag, locked, (m_lkrun > L));
        end
        ncmp++;
        assert (cfg_ready === m_ready()) else begin
            nfail++; $error("FAIL %s cfg_ready: got %b want %b", tag, cfg_ready, m_ready());
        end
        ncmp++;
        assert (cfg_err === m_err) else begin
            nfail++; $error("FAIL %s cfg_err: got %b want %b", tag, cfg_err, m_err);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check(tag);
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] p, input string tag);
        int n = 0;
        bit seen = 1'b0;
        cfg_valid = 1'b1; cfg_chan = ch; cfg_div = d; cfg_phase = p;
        while (!seen && n < 40) begin
            seen = (cfg_ready === 1'b1);
            tick(tag);
            n++;
        end
        cfg_valid = 1'b0;
        ncmp++;
        assert (seen === 1'b1) else begin
            nfail++; $error("FAIL %s accept: got no handshake in %0d cycles, want one", tag, n);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; pll_locked = 1'b0; cfg_valid = 1'b0; cfg_chan = '0;
        cfg_div = '0; cfg_phase = '0; realign = 1'b0;
        model_reset();
        #1;
        check("reset");
        repeat (2) tick("reset_hold");
        rst = 1'b0;

        // Lock-up latency and default strobe pattern.
        repeat (5) tick("wait_pll");
        pll_locked = 1'b1;
        n = 0;
        do begin tick("settle"); n++; end while (locked !== 1'b1 && n < 40);
        ncmp++;
        assert (n === SYNC + 1 + L) else begin
            nfail++; $error("FAIL lock_latency: got %0d cycles want %0d", n, SYNC + 1 + L);
        end
        repeat (12) tick("run_default");

        // One-cycle lock glitch, full re-settle.
        pll_locked = 1'b0;
        tick("lock_drop");
        pll_locked = 1'b1;
        repeat (40) tick("relock");

        // Mid-period divisor change on ch0 with a second request held off.
        tick("mid_period");
        send(2'd0, 8'd3, 8'd0, "cfg_ch0_div3");
        send(2'd1, 8'd4, 8'd0, "cfg_held");
        repeat (12) tick("div3_run");

        // Phase 1 on ch1, then realign.
        send(2'd1, 8'd4, 8'd1, "cfg_ch1_ph1");
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin tick("wait_apply"); n++; end
        ncmp++;
        assert (cfg_ready === 1'b1) else begin
            nfail++; $error("FAIL apply_timeout: cfg_ready got %b want 1", cfg_ready);
        end
        realign = 1'b1;
        tick("realign");
        realign = 1'b0;
        n = 0;
        do begin tick("after_realign"); n++; end while (en[1] !== 1'b1 && n < 8);
        ncmp++;
        assert (n === 2) else begin
            nfail++; $error("FAIL realign_en1: got %0d cycles want 2", n);
        end
        repeat (10) tick("phase_run");

        // Out-of-range channel, then divisor 0.
        send(2'd3, 8'd5, 8'd5, "cfg_bad_chan");
        ncmp++;
        assert (cfg_err === 1'b1) else begin
            nfail++; $error("FAIL cfg_err_pulse: got %b want 1", cfg_err);
        end
        send(2'd0, 8'd0, 8'd0, "cfg_div0");
        repeat (12) tick("div0_run");

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            pll_locked = ($urandom_range(0, 199) != 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_chan   = 2'($urandom_range(0, 3));
            cfg_div    = 8'($urandom_range(0, 6));
            cfg_phase  = 8'($urandom_range(0, 7));
            realign    = ($urandom_range(0, 15) == 0);
            tick("random");
        end
        cfg_valid = 1'b0; realign = 1'b0; pll_locked = 1'b1;
        repeat (30) tick("quiet");

        // Async reset during SETTLE with a request pending.
        pll_locked = 1'b0;
        repeat (3) tick("to_wait");
        pll_locked = 1'b1;
        repeat (6) tick("in_settle");
        send(2'd1, 8'd6, 8'd2, "cfg_pending");
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        repeat (2) tick("rst_hold");
        rst = 1'b0;
        repeat (40) tick("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
